// File: rtl/quad_pkg.sv
// Shared types for the UART command wrapper: framer, RX and TX state
// encodings and the command frame length.
package quad_pkg;

  localparam int FRAME_LEN = 3;

  typedef enum logic [1:0] {
    BYTE1 = 2'd0,
    BYTE2 = 2'd1,
    BYTE3 = 2'd2
  } frame_state_e;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_DATA = 2'd1,
    RX_STOP = 2'd2
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_trx.sv
// UART byte engine: RX synchronizer and deserializer, TX serializer.
// RX and TX run independently (full duplex).
module uart_trx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic       tx_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_vld_o,
  output logic       rx_ferr_o,
  input  logic       tx_start_i,
  input  logic [7:0] tx_byte_i,
  output logic       tx_busy_o,
  output logic       tx_done_o
);
  import quad_pkg::*;

  localparam int CNT_W = $clog2(BAUD_DIV * 3 / 2 + 1);
  // First data sample lands in the middle of bit 0, 1.5 bit times after the start edge.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV * 3 / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BAUD_DIV - 1);

  logic rx_meta_q, rx_sync_q, rx_prev_q;

  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_idx_q, rx_idx_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic             rx_vld_q, rx_vld_d;
  logic             rx_ferr_q, rx_ferr_d;

  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic             tx_q, tx_d;
  logic             tx_done_q, tx_done_d;

  // Two-flop synchronizer for the asynchronous RX line plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // RX next state: start on a synchronized falling edge, sample mid-bit, check stop bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_sh_d    = rx_sh_q;
    rx_vld_d   = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_DATA;
          rx_cnt_d   = HALF_LOAD;
          rx_idx_d   = 3'd0;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
          rx_cnt_d = BIT_LOAD;
          if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_idx_d   = rx_idx_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = RX_IDLE;
          if (rx_sync_q) rx_vld_d  = 1'b1;
          else           rx_ferr_d = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= 3'd0;
      rx_sh_q    <= 8'h00;
      rx_vld_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_sh_q    <= rx_sh_d;
      rx_vld_q   <= rx_vld_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // TX next state: start, 8 data bits LSB first, stop; line value registered from the next state.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_sh_d    = tx_sh_q;
    tx_done_d  = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_start_i) begin
          tx_state_d = TX_START;
          tx_cnt_d   = BIT_LOAD;
          tx_idx_d   = 3'd0;
          tx_sh_d    = tx_byte_i;
        end
      end
      TX_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = BIT_LOAD;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = BIT_LOAD;
          tx_sh_d  = {1'b1, tx_sh_q[7:1]};
          if (tx_idx_q == 3'd7) tx_state_d = TX_STOP;
          else                  tx_idx_d   = tx_idx_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_IDLE;
          tx_done_d  = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    tx_d = 1'b1;
    case (tx_state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_sh_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // TX state register; the line idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= 3'd0;
      tx_sh_q    <= 8'h00;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign tx_o      = tx_q;
  assign rx_byte_o = rx_sh_q;
  assign rx_vld_o  = rx_vld_q;
  assign rx_ferr_o = rx_ferr_q;
  assign tx_busy_o = (tx_state_q != TX_IDLE);
  assign tx_done_o = tx_done_q;

endmodule

// File: rtl/uart_wrapper.sv
// UART command wrapper: assembles 3-byte commands from RX with an
// inter-byte timeout, and transmits response bytes with one pending slot.
module uart_wrapper #(
  parameter int BAUD_DIV = 2604,
  parameter int FAST_SIM = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic        clr_cmd_rdy,
  output logic        cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  input  logic        send_resp,
  input  logic [7:0]  resp,
  output logic        resp_sent
);
  import quad_pkg::*;

  localparam int TO_W = (FAST_SIM != 0) ? 10 : 20;

  logic [7:0] rx_byte;
  logic       rx_vld, rx_ferr;
  logic       tx_start, tx_busy, tx_done;
  logic [7:0] tx_byte;

  frame_state_e    frm_q, frm_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [15:0]     data_q, data_d;
  logic            cmd_rdy_q, cmd_rdy_d;
  logic            pend_q, pend_d;
  logic [7:0]      pend_byte_q, pend_byte_d;

  uart_trx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_trx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_i      (RX),
    .tx_o      (TX),
    .rx_byte_o (rx_byte),
    .rx_vld_o  (rx_vld),
    .rx_ferr_o (rx_ferr),
    .tx_start_i(tx_start),
    .tx_byte_i (tx_byte),
    .tx_busy_o (tx_busy),
    .tx_done_o (tx_done)
  );

  // Framer next state: one step per good byte; framing error or timeout restarts at BYTE1.
  always_comb begin
    frm_d     = frm_q;
    to_d      = to_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    cmd_rdy_d = cmd_rdy_q;
    if (frm_q != BYTE1) to_d = to_q + TO_W'(1);
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
    if (rx_vld) begin
      to_d = '0;
      case (frm_q)
        BYTE1: begin
          cmd_d     = rx_byte;
          cmd_rdy_d = 1'b0;
          frm_d     = BYTE2;
        end
        BYTE2: begin
          data_d[15:8] = rx_byte;
          frm_d        = BYTE3;
        end
        BYTE3: begin
          // Completion overrides a coincident clear.
          data_d[7:0] = rx_byte;
          cmd_rdy_d   = 1'b1;
          frm_d       = BYTE1;
        end
        default: frm_d = BYTE1;
      endcase
    end else if (rx_ferr) begin
      frm_d = BYTE1;
      to_d  = '0;
    end else if ((frm_q != BYTE1) && (to_q == '1)) begin
      frm_d = BYTE1;
      to_d  = '0;
    end
  end

  // Framer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_q     <= BYTE1;
      to_q      <= '0;
      cmd_q     <= 8'h00;
      data_q    <= 16'h0000;
      cmd_rdy_q <= 1'b0;
    end else begin
      frm_q     <= frm_d;
      to_q      <= to_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  // Response launch: direct when TX is idle, otherwise one pending request launched once TX frees.
  always_comb begin
    tx_start    = 1'b0;
    tx_byte     = resp;
    pend_d      = pend_q;
    pend_byte_d = pend_byte_q;
    if (pend_q) begin
      if (!tx_busy) begin
        tx_start = 1'b1;
        tx_byte  = pend_byte_q;
        pend_d   = 1'b0;
      end
    end else if (send_resp) begin
      if (!tx_busy) begin
        tx_start = 1'b1;
      end else begin
        pend_d      = 1'b1;
        pend_byte_d = resp;
      end
    end
  end

  // Pending-response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      pend_byte_q <= 8'h00;
    end else begin
      pend_q      <= pend_d;
      pend_byte_q <= pend_byte_d;
    end
  end

  assign cmd_rdy   = cmd_rdy_q;
  assign cmd       = cmd_q;
  assign data      = data_q;
  assign resp_sent = tx_done;

endmodule

// File: tb/tb_uart_wrapper.sv
// Scoreboard bench for uart_wrapper: directed RX frames and TX responses,
// with independent monitors decoding cmd_rdy events and the TX line.
module tb_uart_wrapper;
  localparam int B = 16;

  logic        clk = 1'b0;
  logic        rst_n, RX, clr_cmd_rdy, send_resp;
  logic [7:0]  resp;
  logic        TX, cmd_rdy, resp_sent;
  logic [7:0]  cmd;
  logic [15:0] data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sent_pulses = 0;
  logic [23:0] exp_cmd_q[$];
  logic [7:0]  exp_tx_q[$];
  int          tx_start_cyc[$];

  uart_wrapper #(.BAUD_DIV(B), .FAST_SIM(1)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX),
    .clr_cmd_rdy(clr_cmd_rdy), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
    .send_resp(send_resp), .resp(resp), .resp_sent(resp_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (resp_sent) sent_pulses <= sent_pulses + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Command monitor: every rising cmd_rdy must match the next expected frame.
  initial begin
    logic prev;
    logic [23:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (cmd_rdy && !prev) begin
        if (exp_cmd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cmd_unexpected got=%0h/%0h expected=none", cmd, data);
        end else begin
          e = exp_cmd_q.pop_front();
          chk("cmd", {24'h0, cmd}, {24'h0, e[23:16]});
          chk("data", {16'h0, data}, {16'h0, e[15:0]});
        end
      end
      prev = cmd_rdy;
    end
  end

  // TX monitor: decode each byte at bit centres and check resp_sent timing.
  initial begin
    logic [7:0] b;
    int t0;
    bit ok;
    forever begin
      @(negedge clk);
      if (rst_n && TX == 1'b0) begin
        t0 = cyc;
        tx_start_cyc.push_back(t0);
        repeat (B / 2) @(negedge clk);
        chk("tx_start_bit", {31'h0, TX}, 32'h0);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          b[i] = TX;
        end
        repeat (B) @(negedge clk);
        chk("tx_stop_bit", {31'h0, TX}, 32'h1);
        if (exp_tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected got=%0h expected=none", b);
        end else begin
          chk("tx_byte", {24'h0, b}, {24'h0, exp_tx_q.pop_front()});
        end
        ok = 1'b0;
        for (int k = 0; k < B; k++) begin
          if (resp_sent) begin
            ok = 1'b1;
            break;
          end
          @(negedge clk);
        end
        if (!ok) begin
          checks++;
          errors++;
          $display("FAIL resp_sent_missing got=0 expected=1");
        end else begin
          chk("resp_sent_time", cyc - t0, 10 * B);
        end
      end
    end
  end

  task automatic rx_byte(input logic [7:0] v, input logic stop, input int gap);
    RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = v[i];
      repeat (B) @(negedge clk);
    end
    RX = stop;
    repeat (B) @(negedge clk);
    RX = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_rdy(input int lim, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < lim; k++) begin
      if (cmd_rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic send(input logic [7:0] v);
    resp = v;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int lim);
    for (int k = 0; k < lim && sent_pulses < n; k++) @(negedge clk);
  endtask

  initial begin
    bit ok;
    RX = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp = 8'h00; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'h0, TX}, 32'h1);
    chk("rst_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
    chk("rst_cmd", {24'h0, cmd}, 32'h0);
    chk("rst_data", {16'h0, data}, 32'h0);
    chk("rst_resp_sent", {31'h0, resp_sent}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic frame, held until cleared.
    exp_cmd_q.push_back(24'h02_1234);
    rx_byte(8'h02, 1'b1, 2 * B);
    rx_byte(8'h12, 1'b1, 2 * B);
    rx_byte(8'h34, 1'b1, 0);
    chk("rdy_after_stop", {31'h0, cmd_rdy}, 32'h1);
    repeat (50) @(negedge clk);
    chk("rdy_held", {31'h0, cmd_rdy}, 32'h1);
    chk("data_held", {16'h0, data}, 32'h1234);
    pulse_clr();
    chk("rdy_cleared", {31'h0, cmd_rdy}, 32'h0);
    chk("cmd_after_clr", {24'h0, cmd}, 32'h02);

    // Single response 0xA5.
    exp_tx_q.push_back(8'hA5);
    send(8'hA5);
    wait_pulses(1, 14 * B);
    repeat (4) @(negedge clk);
    chk("pulses_single", sent_pulses, 1);

    // Partial frame abandoned by timeout, then a full frame.
    exp_cmd_q.push_back(24'h03_0040);
    rx_byte(8'h05, 1'b1, 2 * B);
    rx_byte(8'h01, 1'b1, 0);
    repeat (1200) @(negedge clk);
    chk("no_rdy_partial", {31'h0, cmd_rdy}, 32'h0);
    rx_byte(8'h03, 1'b1, 2 * B);
    rx_byte(8'h00, 1'b1, 2 * B);
    rx_byte(8'h40, 1'b1, 0);
    wait_rdy(20, ok);
    chk("rdy_after_timeout", {31'h0, ok}, 32'h1);
    pulse_clr();

    // Framing error byte dropped; clear held through completion loses to the set.
    exp_cmd_q.push_back(24'h04_FFF0);
    rx_byte(8'h06, 1'b0, 2 * B);
    rx_byte(8'h04, 1'b1, 2 * B);
    rx_byte(8'hFF, 1'b1, 2 * B);
    clr_cmd_rdy = 1'b1;
    rx_byte(8'hF0, 1'b1, 0);
    chk("set_wins_popped", exp_cmd_q.size(), 0);
    chk("clr_after_set", {31'h0, cmd_rdy}, 32'h0);
    clr_cmd_rdy = 1'b0;
    @(negedge clk);

    // Pending response: A5 then 5A back-to-back, 11 dropped.
    exp_tx_q.push_back(8'hA5);
    exp_tx_q.push_back(8'h5A);
    send(8'hA5);
    repeat (3 * B) @(negedge clk);
    send(8'h5A);
    repeat (B) @(negedge clk);
    send(8'h11);
    wait_pulses(3, 30 * B);
    repeat (14 * B) @(negedge clk);
    chk("pulses_total", sent_pulses, 3);
    chk("tx_queue_empty", exp_tx_q.size(), 0);
    chk("tx_start_count", tx_start_cyc.size(), 3);
    if (tx_start_cyc.size() >= 3)
      chk("b2b_gap", tx_start_cyc[2] - tx_start_cyc[1], 10 * B + 1);

    // Reset during byte 2, then a clean frame.
    rx_byte(8'h09, 1'b1, 2 * B);
    RX = 1'b0;
    repeat (B) @(negedge clk);
    RX = 1'b1;
    repeat (B) @(negedge clk);
    RX = 1'b0;
    repeat (B / 2) @(negedge clk);
    rst_n = 1'b0;
    RX = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_cmd", {24'h0, cmd}, 32'h0);
    chk("midrst_data", {16'h0, data}, 32'h0);
    chk("midrst_rdy", {31'h0, cmd_rdy}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    exp_cmd_q.push_back(24'h08_0000);
    rx_byte(8'h08, 1'b1, 2 * B);
    rx_byte(8'h00, 1'b1, 2 * B);
    rx_byte(8'h00, 1'b1, 0);
    wait_rdy(20, ok);
    chk("rdy_after_reset", {31'h0, ok}, 32'h1);
    repeat (10 * B) @(negedge clk);
    pulse_clr();

    repeat (20) @(negedge clk);
    chk("cmd_queue_empty", exp_cmd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_wrapper.md
UART_WRAPPER -- requirements
Module: uart_wrapper

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 2604, clocks per UART bit (19200 baud at 50 MHz).
REQ-002 SHALL have parameter FAST_SIM, default 1; inter-byte timeout = 2^10 clocks if 1, 2^20 clocks if 0.
REQ-003 SHALL have port clk  input  1  system clock; one clock domain.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port RX  input  1  serial line from the remote; asynchronous to clk.
REQ-006 SHALL have port TX  output  1  serial line to the remote.
REQ-007 SHALL have port clr_cmd_rdy  input  1  command consumed; knocks down cmd_rdy.
REQ-008 SHALL have port cmd_rdy  output  1  complete 3-byte command held on cmd/data.
REQ-009 SHALL have port cmd  output  8  command opcode (byte 1).
REQ-010 SHALL have port data  output  16  {byte 2, byte 3}; byte 2 is the MSB.
REQ-011 SHALL have port send_resp  input  1  one-clock request to transmit resp.
REQ-012 SHALL have port resp  input  8  response byte, typically 0xA5.
REQ-013 SHALL have port resp_sent  output  1  one-clock pulse at the end of the response stop bit.

Function
REQ-014 SHALL double-flop RX before any use.
REQ-015 RX: a synchronized falling edge while idle SHALL start reception; bit 0 SHALL be sampled BAUD_DIV*1.5 clocks after the edge, then every BAUD_DIV clocks; 8 bits, LSB first, then the stop bit.
REQ-016 A stop bit sampled 0 SHALL discard the byte (framing error) and return the framer to BYTE1.
REQ-017 The framer SHALL be a state machine BYTE1 -> BYTE2 -> BYTE3 -> BYTE1, advancing once per good byte.
REQ-018 A good byte in BYTE1 SHALL load cmd, clear cmd_rdy in the same cycle, and clear the timeout counter.
REQ-019 A good byte in BYTE2 SHALL load data[15:8]; a good byte in BYTE3 SHALL load data[7:0] and set cmd_rdy on the next clock edge.
REQ-020 A stale cmd_rdy SHALL never coexist with partial new data: cmd and data SHALL hold while cmd_rdy=1 until BYTE1 of a new frame.
REQ-021 cmd_rdy SHALL clear on clr_cmd_rdy; if clr_cmd_rdy and frame completion coincide, the set SHALL win.
REQ-022 In BYTE2/BYTE3, timeout counter saturation SHALL return the framer to BYTE1 without asserting cmd_rdy; the counter SHALL clear on every good byte.
REQ-023 TX SHALL idle high and send: start 0, 8 data bits LSB first, stop 1; each bit is BAUD_DIV clocks.
REQ-024 send_resp while TX idle SHALL capture resp and drive the start bit on the next clock.
REQ-025 send_resp while TX busy SHALL be held as one pending request (resp captured then); a further send_resp while one is pending SHALL be ignored.
REQ-026 A pending request SHALL begin transmission on the clock after resp_sent.
REQ-027 RX and TX SHALL operate fully concurrently (full duplex).

Reset
REQ-028 On rst_n low, the block SHALL set TX=1, cmd_rdy=0, cmd=0x00, data=0x0000, resp_sent=0; framer to BYTE1; RX/TX engines idle; pending request cleared; counters 0.
REQ-029 A reset mid-frame or mid-transmission SHALL abort immediately; no partial byte or command SHALL survive.

Structure
REQ-030 SHALL place framer state enum, TX/RX state enums, and frame length (3) in shared package quad_pkg.
REQ-031 SHALL instantiate exactly one sub-module, uart_trx (synchronizer, RX deserializer, TX serializer, baud counters); the framer, timeout and pending-response logic SHALL sit in uart_wrapper.

Verification
REQ-032 Frame 0x02,0x12,0x34 on RX -> cmd=0x02, data=0x1234, cmd_rdy=1 within 2 clocks after the byte-3 stop sample; held until clr_cmd_rdy.
REQ-033 send_resp with resp=0xA5 -> TX bit sequence 0,1,0,1,0,0,1,0,1,1 at BAUD_DIV clocks per bit; resp_sent pulses once, 10*BAUD_DIV clocks after start.
REQ-034 Bytes 0x05,0x01, then silence > 2^10 clocks (FAST_SIM=1), then 0x03,0x00,0x40 -> cmd=0x03, data=0x0040; no cmd_rdy before byte 3 of the second frame.
REQ-035 Byte 0x06 with stop bit forced 0, then 0x04,0xFF,0xF0 -> cmd=0x04, data=0xFFF0; the bad byte is never loaded.
REQ-036 send_resp 0xA5, then send_resp 0x5A mid-transmission, then send_resp 0x11 -> 0xA5 then 0x5A back-to-back; 0x11 is never sent; 2 resp_sent pulses.
REQ-037 rst_n low during byte 2 of a frame, then full frame 0x08,0x00,0x00 -> cmd=0x08, data=0x0000, single cmd_rdy.
